// File: rtl/rv_ctrl_pkg.sv
// Shared encodings, opcodes and per-stage control structs for the RV32I pipeline controller.
// Pure declarations; no timing or flow control of its own.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [1:0] ALUDEC_ADD   = 2'b00;
    localparam logic [1:0] ALUDEC_SUB   = 2'b01;
    localparam logic [1:0] ALUDEC_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        alu_op_e     alu_ctrl;
        logic        pc_target_src;
        logic [2:0]  funct3;
    } ctrl_e_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } ctrl_w_t;

    // funct3 values 010/011 are not branch encodings and never redirect.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lt,
                                         input logic       ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Main + ALU decoder for the D stage; purely combinational, zero latency.
// No flow control: the result is consumed by the D->E register in the top level.
module rv_decode
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned EN_JALR = 1
) (
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output ctrl_e_t    ctrl_o,
    output imm_src_e   imm_src_o,
    output logic       illegal_o
);

    logic [1:0] alu_dec;

    always_comb begin
        ctrl_o        = '0;
        imm_src_o     = IMM_I;
        illegal_o     = 1'b0;
        alu_dec       = ALUDEC_ADD;
        ctrl_o.funct3 = funct3_i;

        case (op_i)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src_o        = IMM_S;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                alu_dec          = ALUDEC_FUNCT;
            end
            OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                alu_dec          = ALUDEC_FUNCT;
            end
            OP_BRANCH: begin
                imm_src_o     = IMM_B;
                ctrl_o.branch = 1'b1;
                alu_dec       = ALUDEC_SUB;
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                imm_src_o         = IMM_J;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.jump       = 1'b1;
            end
            OP_JALR: begin
                if (EN_JALR != 0) begin
                    ctrl_o.reg_write     = 1'b1;
                    ctrl_o.alu_src       = 1'b1;
                    ctrl_o.result_src    = RES_PC4;
                    ctrl_o.jump          = 1'b1;
                    ctrl_o.pc_target_src = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_LUI: begin
                ctrl_o.reg_write  = 1'b1;
                imm_src_o         = IMM_U;
                ctrl_o.result_src = RES_IMM;
            end
            default: illegal_o = 1'b1;
        endcase

        // op[5] separates R-type (sub allowed) from I-type, where instr[30] is immediate data.
        case (alu_dec)
            ALUDEC_SUB: ctrl_o.alu_ctrl = ALU_SUB;
            ALUDEC_FUNCT: begin
                case (funct3_i)
                    3'b000:  ctrl_o.alu_ctrl = (op_i[5] & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl_o.alu_ctrl = ALU_SLL;
                    3'b010:  ctrl_o.alu_ctrl = ALU_SLT;
                    3'b011:  ctrl_o.alu_ctrl = ALU_SLTU;
                    3'b100:  ctrl_o.alu_ctrl = ALU_XOR;
                    3'b101:  ctrl_o.alu_ctrl = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl_o.alu_ctrl = ALU_OR;
                    default: ctrl_o.alu_ctrl = ALU_AND;
                endcase
            end
            default: ctrl_o.alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_pipe_controller.sv
// RV32I pipeline control: decode in D, registered D->E->M->W (1/2/3 cycles), branch resolve in E.
// Backpressure: StallE holds E and bubbles M; FlushE zeroes E and wins over StallE.
module rv_pipe_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned IMMSRC_W  = 3,
    parameter int unsigned EN_JALR   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [IMMSRC_W-1:0]  ImmSrcD,
    output logic                 IllegalD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 PCSrcE,
    output logic                 PCTargetSrcE,
    output logic                 ResultSrcE0,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    ctrl_e_t    ctrl_d;
    imm_src_e   imm_src_d;
    logic [2:0] imm_bits;
    logic [3:0] alu_bits;

    ctrl_e_t ctrl_e_q, ctrl_e_d;
    ctrl_m_t ctrl_m_q, ctrl_m_d;
    ctrl_w_t ctrl_w_q, ctrl_w_d;

    rv_decode #(
        .EN_JALR (EN_JALR)
    ) u_decode (
        .op_i       (opD),
        .funct3_i   (funct3D),
        .funct7b5_i (funct7b5D),
        .ctrl_o     (ctrl_d),
        .imm_src_o  (imm_src_d),
        .illegal_o  (IllegalD)
    );

    always_comb begin
        ctrl_e_d = ctrl_e_q;
        if (FlushE) begin
            ctrl_e_d = '0;
        end else if (!StallE) begin
            ctrl_e_d = ctrl_d;
        end
    end

    // A held E instruction must not also be issued into M, so M sees a bubble.
    always_comb begin
        ctrl_m_d            = '0;
        if (!(StallE && !FlushE)) begin
            ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
            ctrl_m_d.result_src = ctrl_e_q.result_src;
            ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
        end
    end

    always_comb begin
        ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
        ctrl_w_d.result_src = ctrl_m_q.result_src;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q <= '0;
            ctrl_m_q <= '0;
            ctrl_w_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            ctrl_m_q <= ctrl_m_d;
            ctrl_w_q <= ctrl_w_d;
        end
    end

    assign imm_bits     = imm_src_d;
    assign alu_bits     = ctrl_e_q.alu_ctrl;
    assign ImmSrcD      = IMMSRC_W'(imm_bits);
    assign ALUControlE  = ALUCTRL_W'(alu_bits);
    assign ALUSrcE      = ctrl_e_q.alu_src;
    assign PCTargetSrcE = ctrl_e_q.pc_target_src;
    assign ResultSrcE0  = ctrl_e_q.result_src[0] & ~ctrl_e_q.result_src[1];

    // Redirect is suppressed while E is held so it fires once, on the release cycle.
    assign PCSrcE = ((ctrl_e_q.branch & branch_cond(ctrl_e_q.funct3, ZeroE, LtE, LtuE))
                     | ctrl_e_q.jump) & ~StallE;

    assign RegWriteM  = ctrl_m_q.reg_write;
    assign MemWriteM  = ctrl_m_q.mem_write;
    assign RegWriteW  = ctrl_w_q.reg_write;
    assign ResultSrcW = ctrl_w_q.result_src;

endmodule

// File: tb/tb_rv_pipe_controller.sv
// Directed bench: decode/pipeline vector table plus reset, stall and flush sequences.
module tb_rv_pipe_controller;

    localparam int NV = 24;
    localparam logic [6:0] JALR_OP = 7'b1100111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D;
    logic       StallE, FlushE, ZeroE, LtE, LtuE;

    logic [2:0] ImmSrcD;
    logic       IllegalD, ALUSrcE, PCSrcE, PCTargetSrcE, ResultSrcE0;
    logic [3:0] ALUControlE;
    logic       RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW;

    logic [2:0] nj_ImmSrcD;
    logic       nj_IllegalD, nj_ALUSrcE, nj_PCSrcE, nj_PCTargetSrcE, nj_ResultSrcE0;
    logic [4:0] nj_ALUControlE;
    logic       nj_RegWriteM, nj_MemWriteM, nj_RegWriteW;
    logic [1:0] nj_ResultSrcW;

    int ncheck = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    rv_pipe_controller dut (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE), .ResultSrcE0(ResultSrcE0),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW)
    );

    rv_pipe_controller #(.ALUCTRL_W(5), .IMMSRC_W(3), .EN_JALR(0)) u_nj (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .ImmSrcD(nj_ImmSrcD), .IllegalD(nj_IllegalD), .ALUSrcE(nj_ALUSrcE),
        .ALUControlE(nj_ALUControlE), .PCSrcE(nj_PCSrcE), .PCTargetSrcE(nj_PCTargetSrcE),
        .ResultSrcE0(nj_ResultSrcE0), .RegWriteM(nj_RegWriteM), .MemWriteM(nj_MemWriteM),
        .RegWriteW(nj_RegWriteW), .ResultSrcW(nj_ResultSrcW)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z, lt, ltu;
        logic [2:0] imm;
        logic       ill;
        logic       alusrc;
        logic [3:0] alu;
        logic       pcsrc, pcts, rs0;
        logic       rw, mw;
        logic [1:0] rs;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input logic lt, input logic ltu,
                                input logic [2:0] imm, input logic ill, input logic alusrc,
                                input logic [3:0] alu, input logic pcsrc, input logic pcts,
                                input logic rs0, input logic rw, input logic mw,
                                input logic [1:0] rs);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
        v.imm = imm; v.ill = ill; v.alusrc = alusrc; v.alu = alu; v.pcsrc = pcsrc;
        v.pcts = pcts; v.rs0 = rs0; v.rw = rw; v.mw = mw; v.rs = rs;
        return v;
    endfunction

    // Expected behaviour of the instance built without jalr support.
    function automatic vec_t nj_of(input vec_t v);
        vec_t n;
        n = v;
        if (v.op == JALR_OP) begin
            n.imm = 3'b000; n.ill = 1'b1; n.alusrc = 1'b0; n.alu = 4'd0; n.pcsrc = 1'b0;
            n.pcts = 1'b0; n.rs0 = 1'b0; n.rw = 1'b0; n.mw = 1'b0; n.rs = 2'b00;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_d(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opD = op; funct3D = f3; funct7b5D = f7;
    endtask

    initial begin
        //              op          f3     f7  z  lt ltu imm  il as alu  pc pt r0 rw mw rs
        tbl[0]  = mk(7'b0000011, 3'b010, 0, 0, 0, 0, 3'd0, 0, 1, 4'd0, 0, 0, 1, 1, 0, 2'b01); // lw
        tbl[1]  = mk(7'b0100011, 3'b010, 0, 0, 0, 0, 3'd1, 0, 1, 4'd0, 0, 0, 0, 0, 1, 2'b00); // sw
        tbl[2]  = mk(7'b0110011, 3'b000, 1, 0, 0, 0, 3'd0, 0, 0, 4'd1, 0, 0, 0, 1, 0, 2'b00); // sub
        tbl[3]  = mk(7'b0010011, 3'b000, 1, 0, 0, 0, 3'd0, 0, 1, 4'd0, 0, 0, 0, 1, 0, 2'b00); // addi i30=1
        tbl[4]  = mk(7'b0010011, 3'b101, 1, 0, 0, 0, 3'd0, 0, 1, 4'd9, 0, 0, 0, 1, 0, 2'b00); // srai
        tbl[5]  = mk(7'b0110011, 3'b101, 0, 0, 0, 0, 3'd0, 0, 0, 4'd8, 0, 0, 0, 1, 0, 2'b00); // srl
        tbl[6]  = mk(7'b0110011, 3'b111, 0, 0, 0, 0, 3'd0, 0, 0, 4'd2, 0, 0, 0, 1, 0, 2'b00); // and
        tbl[7]  = mk(7'b0010011, 3'b110, 0, 0, 0, 0, 3'd0, 0, 1, 4'd3, 0, 0, 0, 1, 0, 2'b00); // ori
        tbl[8]  = mk(7'b0110011, 3'b100, 0, 0, 0, 0, 3'd0, 0, 0, 4'd4, 0, 0, 0, 1, 0, 2'b00); // xor
        tbl[9]  = mk(7'b0110011, 3'b010, 0, 0, 0, 0, 3'd0, 0, 0, 4'd5, 0, 0, 0, 1, 0, 2'b00); // slt
        tbl[10] = mk(7'b0010011, 3'b011, 0, 0, 0, 0, 3'd0, 0, 1, 4'd6, 0, 0, 0, 1, 0, 2'b00); // sltiu
        tbl[11] = mk(7'b0110011, 3'b001, 0, 0, 0, 0, 3'd0, 0, 0, 4'd7, 0, 0, 0, 1, 0, 2'b00); // sll
        tbl[12] = mk(7'b1100011, 3'b000, 0, 1, 0, 0, 3'd2, 0, 0, 4'd1, 1, 0, 0, 0, 0, 2'b00); // beq z=1
        tbl[13] = mk(7'b1100011, 3'b101, 0, 0, 1, 0, 3'd2, 0, 0, 4'd1, 0, 0, 0, 0, 0, 2'b00); // bge lt=1
        tbl[14] = mk(7'b1100011, 3'b110, 0, 0, 0, 1, 3'd2, 0, 0, 4'd1, 1, 0, 0, 0, 0, 2'b00); // bltu ltu=1
        tbl[15] = mk(7'b1100011, 3'b001, 0, 1, 0, 0, 3'd2, 0, 0, 4'd1, 0, 0, 0, 0, 0, 2'b00); // bne z=1
        tbl[16] = mk(7'b1100011, 3'b100, 0, 0, 1, 0, 3'd2, 0, 0, 4'd1, 1, 0, 0, 0, 0, 2'b00); // blt lt=1
        tbl[17] = mk(7'b1100011, 3'b111, 0, 0, 0, 0, 3'd2, 0, 0, 4'd1, 1, 0, 0, 0, 0, 2'b00); // bgeu ltu=0
        tbl[18] = mk(7'b1100011, 3'b010, 0, 1, 1, 1, 3'd2, 0, 0, 4'd1, 0, 0, 0, 0, 0, 2'b00); // f3=010 never
        tbl[19] = mk(7'b1101111, 3'b000, 0, 0, 0, 0, 3'd3, 0, 0, 4'd0, 1, 0, 0, 1, 0, 2'b10); // jal
        tbl[20] = mk(7'b1100111, 3'b000, 0, 0, 0, 0, 3'd0, 0, 1, 4'd0, 1, 1, 0, 1, 0, 2'b10); // jalr
        tbl[21] = mk(7'b0110111, 3'b000, 0, 0, 0, 0, 3'd4, 0, 0, 4'd0, 0, 0, 0, 1, 0, 2'b11); // lui
        tbl[22] = mk(7'b1111111, 3'b000, 0, 0, 0, 0, 3'd0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00); // illegal
        tbl[23] = mk(7'b0110011, 3'b000, 0, 0, 0, 0, 3'd0, 0, 0, 4'd0, 0, 0, 0, 1, 0, 2'b00); // add

        reset = 1'b1;
        StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        drive_d(7'b0000011, 3'b010, 1'b0);
        #1;
        chk("rst_alusrc", 32'(ALUSrcE), 0);
        chk("rst_aluctl", 32'(ALUControlE), 0);
        chk("rst_pcsrc", 32'(PCSrcE), 0);
        chk("rst_pcts", 32'(PCTargetSrcE), 0);
        chk("rst_rs0", 32'(ResultSrcE0), 0);
        chk("rst_rwm", 32'(RegWriteM), 0);
        chk("rst_mwm", 32'(MemWriteM), 0);
        chk("rst_rww", 32'(RegWriteW), 0);
        chk("rst_rsw", 32'(ResultSrcW), 0);
        chk("rst_ill", 32'(IllegalD), 0);
        #1 reset = 1'b0;

        for (int k = 0; k < NV + 3; k++) begin
            vec_t ve, vm, vw, ne, nm, nw;
            @(negedge clk);
            if (k < NV) drive_d(tbl[k].op, tbl[k].f3, tbl[k].f7);
            else        drive_d(7'b0010011, 3'b000, 1'b0);
            if (k >= 1 && k <= NV) begin
                ZeroE = tbl[k-1].z; LtE = tbl[k-1].lt; LtuE = tbl[k-1].ltu;
            end else begin
                ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
            end
            #1;
            if (k < NV) begin
                ne = nj_of(tbl[k]);
                chk($sformatf("imm[%0d]", k), 32'(ImmSrcD), 32'(tbl[k].imm));
                chk($sformatf("ill[%0d]", k), 32'(IllegalD), 32'(tbl[k].ill));
                chk($sformatf("nj_imm[%0d]", k), 32'(nj_ImmSrcD), 32'(ne.imm));
                chk($sformatf("nj_ill[%0d]", k), 32'(nj_IllegalD), 32'(ne.ill));
            end
            if (k >= 1 && k <= NV) begin
                ve = tbl[k-1];
                ne = nj_of(ve);
                chk($sformatf("alusrc[%0d]", k-1), 32'(ALUSrcE), 32'(ve.alusrc));
                chk($sformatf("aluctl[%0d]", k-1), 32'(ALUControlE), 32'(ve.alu));
                chk($sformatf("pcsrc[%0d]", k-1), 32'(PCSrcE), 32'(ve.pcsrc));
                chk($sformatf("pcts[%0d]", k-1), 32'(PCTargetSrcE), 32'(ve.pcts));
                chk($sformatf("rs0[%0d]", k-1), 32'(ResultSrcE0), 32'(ve.rs0));
                chk($sformatf("nj_alusrc[%0d]", k-1), 32'(nj_ALUSrcE), 32'(ne.alusrc));
                chk($sformatf("nj_aluctl[%0d]", k-1), 32'(nj_ALUControlE), 32'(ne.alu));
                chk($sformatf("nj_pcsrc[%0d]", k-1), 32'(nj_PCSrcE), 32'(ne.pcsrc));
                chk($sformatf("nj_pcts[%0d]", k-1), 32'(nj_PCTargetSrcE), 32'(ne.pcts));
                chk($sformatf("nj_rs0[%0d]", k-1), 32'(nj_ResultSrcE0), 32'(ne.rs0));
            end
            if (k >= 2 && k <= NV + 1) begin
                vm = tbl[k-2];
                nm = nj_of(vm);
                chk($sformatf("rwm[%0d]", k-2), 32'(RegWriteM), 32'(vm.rw));
                chk($sformatf("mwm[%0d]", k-2), 32'(MemWriteM), 32'(vm.mw));
                chk($sformatf("nj_rwm[%0d]", k-2), 32'(nj_RegWriteM), 32'(nm.rw));
                chk($sformatf("nj_mwm[%0d]", k-2), 32'(nj_MemWriteM), 32'(nm.mw));
            end
            if (k >= 3) begin
                vw = tbl[k-3];
                nw = nj_of(vw);
                chk($sformatf("rww[%0d]", k-3), 32'(RegWriteW), 32'(vw.rw));
                chk($sformatf("rsw[%0d]", k-3), 32'(ResultSrcW), 32'(vw.rs));
                chk($sformatf("nj_rww[%0d]", k-3), 32'(nj_RegWriteW), 32'(nw.rw));
                chk($sformatf("nj_rsw[%0d]", k-3), 32'(nj_ResultSrcW), 32'(nw.rs));
            end
        end
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;

        // Mid-stream reset with lw/sw/lw in E/M/W.
        @(negedge clk) drive_d(7'b0000011, 3'b010, 1'b0);
        @(negedge clk) drive_d(7'b0100011, 3'b010, 1'b0);
        @(negedge clk) drive_d(7'b0000011, 3'b010, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_rs0", 32'(ResultSrcE0), 1);
        chk("pre_rst_mwm", 32'(MemWriteM), 1);
        chk("pre_rst_rww", 32'(RegWriteW), 1);
        reset = 1'b1;
        #1;
        chk("arst_alusrc", 32'(ALUSrcE), 0);
        chk("arst_rs0", 32'(ResultSrcE0), 0);
        chk("arst_mwm", 32'(MemWriteM), 0);
        chk("arst_rww", 32'(RegWriteW), 0);
        chk("arst_rsw", 32'(ResultSrcW), 0);
        @(negedge clk);
        reset = 1'b0;
        drive_d(7'b0000011, 3'b010, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_e_rs0", 32'(ResultSrcE0), 1);
        chk("post_rst_e_rww", 32'(RegWriteW), 0);
        drive_d(7'b1111111, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_m_rwm", 32'(RegWriteM), 1);
        chk("post_rst_m_rww", 32'(RegWriteW), 0);
        @(negedge clk);
        #1;
        chk("post_rst_w_rww", 32'(RegWriteW), 1);
        chk("post_rst_w_rsw", 32'(ResultSrcW), 1);

        // sw held in E for two cycles: M must see it exactly once.
        @(negedge clk) drive_d(7'b0100011, 3'b010, 1'b0);
        @(negedge clk);
        drive_d(7'b0110011, 3'b000, 1'b1);
        StallE = 1'b1;
        begin
            int mw_cnt;
            mw_cnt = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1;
                if (MemWriteM) mw_cnt++;
                if (i < 2) begin
                    chk($sformatf("stall_aluctl[%0d]", i), 32'(ALUControlE), 0);
                    chk($sformatf("stall_alusrc[%0d]", i), 32'(ALUSrcE), 1);
                    chk($sformatf("stall_mwm[%0d]", i), 32'(MemWriteM), 0);
                end
                if (i == 1) StallE = 1'b0;
                if (i == 2) begin
                    chk("release_mwm", 32'(MemWriteM), 1);
                    chk("release_aluctl", 32'(ALUControlE), 1);
                    drive_d(7'b1111111, 3'b000, 1'b0);
                end
            end
            chk("sw_mw_count", 32'(mw_cnt), 1);
        end

        // Taken beq masked while stalled, visible the same cycle stall drops.
        @(negedge clk) drive_d(7'b1100011, 3'b000, 1'b0);
        @(negedge clk);
        drive_d(7'b1111111, 3'b000, 1'b0);
        ZeroE = 1'b1;
        StallE = 1'b1;
        #1 chk("beq_stall_pcsrc", 32'(PCSrcE), 0);
        StallE = 1'b0;
        #1 chk("beq_release_pcsrc", 32'(PCSrcE), 1);
        ZeroE = 1'b0;

        // Stall and flush together: flush wins, lw in E moves on to M.
        @(negedge clk) drive_d(7'b0000011, 3'b010, 1'b0);
        @(negedge clk);
        #1 chk("sf_pre_rs0", 32'(ResultSrcE0), 1);
        StallE = 1'b1;
        FlushE = 1'b1;
        @(negedge clk);
        #1;
        chk("sf_e_rs0", 32'(ResultSrcE0), 0);
        chk("sf_e_alusrc", 32'(ALUSrcE), 0);
        chk("sf_m_rwm", 32'(RegWriteM), 1);
        StallE = 1'b0;
        FlushE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
